aha_periph_reset_sequencer: RTL and testbench

- Sequences software-requested peripheral resets for the platform controller.
- Consumes the reset-request register bits and the clock-gate-enable register bits.
- Drives per-peripheral active-low resets and clock enables, and returns the reset-acknowledge bits to the register space.
- One shared sequencer FSM serves all peripherals, granted round-robin, so only one peripheral is ever mid-reset.

---
 rtl/aha_periph_reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_aha_periph_reset_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aha_periph_reset_sequencer.sv
// Round-robin peripheral reset sequencer: one shared FSM walks each requested peripheral through
// reset, clock-gate, release and ungate, then acks. Define AHA_RST_SEQ_IRQ_EN for done_irq_o/last_idx_o.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | arbitrate pending requests round-robin from ptr
// S_ASSERT  | reset low, clock forced on for RESET_CYCLES
// S_GATE    | reset low, clock forced off for GATE_CYCLES
// S_RELEASE | reset released, clock still forced off for RELEASE_CYCLES
// S_UNGATE  | force removed, clock follows software enable (1 cycle)
// S_DONE    | ack follows the still-live request (1 cycle)
module aha_periph_reset_sequencer #(
    parameter int NUM_PERIPH     = 11,
    parameter int RESET_CYCLES   = 16,
    parameter int GATE_CYCLES    = 4,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NUM_PERIPH-1:0] req_i,
    input  logic [NUM_PERIPH-1:0] clk_gate_en_i,
    output logic [NUM_PERIPH-1:0] ack_o,
    output logic [NUM_PERIPH-1:0] periph_rst_n_o,
    output logic [NUM_PERIPH-1:0] clk_en_o,
    output logic                  busy_o,
    output logic [3:0]            cur_idx_o
`ifdef AHA_RST_SEQ_IRQ_EN
    ,
    output logic                  done_irq_o,
    output logic [3:0]            last_idx_o
`endif
);

    localparam int MAX_RG  = (RESET_CYCLES > GATE_CYCLES) ? RESET_CYCLES : GATE_CYCLES;
    localparam int MAX_CYC = (MAX_RG > RELEASE_CYCLES) ? MAX_RG : RELEASE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = $clog2(NUM_PERIPH);

    typedef enum logic [2:0] {
        S_IDLE, S_ASSERT, S_GATE, S_RELEASE, S_UNGATE, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_load;
    logic [3:0]              ptr, idx, idx_nxt, grant_idx;
    logic                    grant_vld;
    logic [NUM_PERIPH-1:0]   pending, ack_nxt, rst_n_nxt;
    logic                    force_en, force_val, force_en_nxt, force_val_nxt;

    // Lowest rotation offset wins, so iterate from the far end and let the last hit stand.
    always_comb begin
        int j;
        j         = 0;
        pending   = req_i & ~ack_o;
        if (busy_o) pending[cur_idx_o] = 1'b0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_PERIPH - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_PERIPH) j = j - NUM_PERIPH;
            if (pending[IDX_W'(j)]) begin
                grant_vld = 1'b1;
                grant_idx = 4'(j);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= cnt_load;
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (grant_vld)  state_nxt = S_ASSERT;
            S_ASSERT:  if (cnt == '0)  state_nxt = S_GATE;
            S_GATE:    if (cnt == '0)  state_nxt = S_RELEASE;
            S_RELEASE: if (cnt == '0)  state_nxt = S_UNGATE;
            S_UNGATE:                  state_nxt = S_DONE;
            S_DONE:                    state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
        case (state_nxt)
            S_ASSERT:  cnt_load = CNT_W'(RESET_CYCLES - 1);
            S_GATE:    cnt_load = CNT_W'(GATE_CYCLES - 1);
            S_RELEASE: cnt_load = CNT_W'(RELEASE_CYCLES - 1);
            default:   cnt_load = '0;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        rst_n_nxt     = '1;
        force_en_nxt  = 1'b0;
        force_val_nxt = 1'b0;
        idx_nxt       = idx;
        ack_nxt       = ack_o & req_i;
        if (state == S_IDLE && grant_vld) idx_nxt = grant_idx;
        case (state_nxt)
            S_ASSERT: begin
                rst_n_nxt[idx_nxt] = 1'b0;
                force_en_nxt       = 1'b1;
                force_val_nxt      = 1'b1;
            end
            S_GATE: begin
                rst_n_nxt[idx_nxt] = 1'b0;
                force_en_nxt       = 1'b1;
            end
            S_RELEASE: force_en_nxt = 1'b1;
            default: ;
        endcase
        if (state == S_DONE) ack_nxt[idx] = req_i[idx];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ack_o          <= '0;
            periph_rst_n_o <= '1;
            force_en       <= 1'b0;
            force_val      <= 1'b0;
            idx            <= '0;
            ptr            <= '0;
        end else begin
            ack_o          <= ack_nxt;
            periph_rst_n_o <= rst_n_nxt;
            force_en       <= force_en_nxt;
            force_val      <= force_val_nxt;
            idx            <= idx_nxt;
            if (state == S_IDLE && grant_vld)
                ptr <= (grant_idx == 4'(NUM_PERIPH - 1)) ? 4'd0 : grant_idx + 4'd1;
        end
    end

    always_comb begin
        clk_en_o = clk_gate_en_i;
        if (force_en) clk_en_o[idx] = force_val;
    end

    assign busy_o    = (state != S_IDLE);
    assign cur_idx_o = idx;

`ifdef AHA_RST_SEQ_IRQ_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            done_irq_o <= 1'b0;
            last_idx_o <= '0;
        end else begin
            done_irq_o <= (state_nxt == S_DONE);
            if (state == S_DONE) last_idx_o <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_aha_periph_reset_sequencer.sv
// Self-checking bench for aha_periph_reset_sequencer: per-scenario tasks plus a grant/ack scoreboard monitor.
`timescale 1ns/1ps
module tb_aha_periph_reset_sequencer;
    localparam int N       = 11;
    localparam int RC      = 16;
    localparam int GC      = 4;
    localparam int LC      = 4;
    localparam int SEQ_LEN = RC + GC + LC + 3;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] clk_gate_en_i = '1;
    logic [N-1:0] ack_o, periph_rst_n_o, clk_en_o;
    logic         busy_o;
    logic [3:0]   cur_idx_o;
`ifdef AHA_RST_SEQ_IRQ_EN
    logic         done_irq_o;
    logic [3:0]   last_idx_o;
`endif

    int checks = 0;
    int passed = 0;
    int exp_grant_q[$];
    bit exp_ack_q[$];

    aha_periph_reset_sequencer dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .clk_gate_en_i(clk_gate_en_i),
        .ack_o(ack_o), .periph_rst_n_o(periph_rst_n_o), .clk_en_o(clk_en_o),
        .busy_o(busy_o), .cur_idx_o(cur_idx_o)
`ifdef AHA_RST_SEQ_IRQ_EN
        , .done_irq_o(done_irq_o), .last_idx_o(last_idx_o)
`endif
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: grants and completions popped against expectations queued by the tasks.
    logic       mon_busy = 1'b0;
    int         mon_idx = 0;
    int         irq_cnt = 0;
    always @(negedge HCLK) begin
        logic [N-1:0] mask;
        if (!HRESETn) begin
            mon_busy = 1'b0;
        end else begin
            mask = '1;
            if (busy_o) mask[cur_idx_o] = 1'b0;
            checks++;
            if (((clk_en_o ^ clk_gate_en_i) & mask) !== '0 || (periph_rst_n_o | ~mask) !== '1)
                $display("FAIL passthrough: clk_en=%h gate=%h rst_n=%h mask=%h",
                         clk_en_o, clk_gate_en_i, periph_rst_n_o, mask);
            else passed++;
`ifdef AHA_RST_SEQ_IRQ_EN
            if (done_irq_o) begin
                irq_cnt++;
                checks++;
                if (busy_o !== 1'b1) $display("FAIL irq_when_idle: busy=%b required 1", busy_o);
                else passed++;
            end
`endif
            if (busy_o && !mon_busy) begin
                mon_idx = int'(cur_idx_o);
                irq_cnt = 0;
                checks++;
                if (exp_grant_q.size() == 0)
                    $display("FAIL grant_order: got unexpected grant %0d", mon_idx);
                else begin
                    int g;
                    g = exp_grant_q.pop_front();
                    if (g != mon_idx) $display("FAIL grant_order: got %0d required %0d", mon_idx, g);
                    else passed++;
                end
            end else if (busy_o && mon_busy) begin
                checks++;
                if (int'(cur_idx_o) != mon_idx)
                    $display("FAIL idx_stable: got %0d required %0d", cur_idx_o, mon_idx);
                else passed++;
            end else if (!busy_o && mon_busy) begin
                checks++;
                if (exp_ack_q.size() == 0)
                    $display("FAIL ack_result: unexpected completion of %0d", mon_idx);
                else begin
                    bit a;
                    a = exp_ack_q.pop_front();
                    if (ack_o[mon_idx] !== a)
                        $display("FAIL ack_result: idx %0d ack=%b required %b", mon_idx, ack_o[mon_idx], a);
                    else passed++;
                end
`ifdef AHA_RST_SEQ_IRQ_EN
                checks++;
                if (irq_cnt != 1) $display("FAIL irq_count: got %0d required 1", irq_cnt);
                else passed++;
                checks++;
                if (int'(last_idx_o) != mon_idx)
                    $display("FAIL last_idx: got %0d required %0d", last_idx_o, mon_idx);
                else passed++;
`endif
            end
            mon_busy = busy_o;
        end
    end

    task automatic do_reset();
        HRESETn = 1'b0;
        req_i   = '0;
        exp_grant_q.delete();
        exp_ack_q.delete();
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    task automatic wait_ack(input logic [N-1:0] target, input string name);
        int n;
        n = 0;
        while (ack_o !== target && n < 200) begin
            @(posedge HCLK); @(negedge HCLK);
            n++;
        end
        checks++;
        if (ack_o !== target) $display("FAIL %s: ack=%h required %h", name, ack_o, target);
        else passed++;
    endtask

    task automatic drop_and_check(input string name);
        @(posedge HCLK); #1 req_i = '0;
        @(posedge HCLK); @(negedge HCLK);
        checks++;
        if (ack_o !== '0) $display("FAIL %s: ack=%h required 0", name, ack_o);
        else passed++;
    endtask

    task automatic test_reset();
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        req_i = '0;
        clk_gate_en_i = 11'h5A3;
        #1;
        checks++;
        if (ack_o !== '0) $display("FAIL reset_ack: got %h required 0", ack_o); else passed++;
        checks++;
        if (periph_rst_n_o !== '1) $display("FAIL reset_rst_n: got %h required 7ff", periph_rst_n_o); else passed++;
        checks++;
        if (busy_o !== 1'b0 || cur_idx_o !== 4'd0)
            $display("FAIL reset_busy_idx: busy=%b idx=%0d required 0/0", busy_o, cur_idx_o);
        else passed++;
        checks++;
        if (clk_en_o !== 11'h5A3) $display("FAIL reset_clk_en: got %h required 5a3", clk_en_o); else passed++;
        clk_gate_en_i = '1;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_i[3] = 1'b1;
        exp_grant_q.push_back(3);
        exp_ack_q.push_back(1'b1);
        for (int k = 1; k <= SEQ_LEN; k++) begin
            logic [3:0] exp_v, got_v;
            @(posedge HCLK); @(negedge HCLK);
            exp_v[3] = !(k <= RC + GC);
            exp_v[2] = (k <= RC) ? 1'b1 : (k <= RC + GC + LC) ? 1'b0 : clk_gate_en_i[3];
            exp_v[1] = (k <= SEQ_LEN - 1);
            exp_v[0] = (k >= SEQ_LEN);
            got_v = {periph_rst_n_o[3], clk_en_o[3], busy_o, ack_o[3]};
            checks++;
            if (got_v !== exp_v)
                $display("FAIL single_cycle%0d: {rst_n,clk_en,busy,ack}=%b required %b", k, got_v, exp_v);
            else passed++;
        end
        @(posedge HCLK); #1 req_i[3] = 1'b0;
        @(negedge HCLK);
        checks++;
        if (ack_o[3] !== 1'b1) $display("FAIL single_ack_hold: got %b required 1", ack_o[3]); else passed++;
        @(posedge HCLK); @(negedge HCLK);
        checks++;
        if (ack_o[3] !== 1'b0) $display("FAIL single_ack_clear: got %b required 0", ack_o[3]); else passed++;
    endtask

    task automatic test_ptr_reset();
        do_reset();
        req_i = 11'h022;
        exp_grant_q.push_back(1); exp_ack_q.push_back(1'b1);
        exp_grant_q.push_back(5); exp_ack_q.push_back(1'b1);
        wait_ack(11'h022, "ptr_reset_ack");
        drop_and_check("ptr_reset_clear");
    endtask

    task automatic test_round_robin();
        do_reset();
        req_i = 11'h00A;
        exp_grant_q.push_back(1); exp_ack_q.push_back(1'b1);
        exp_grant_q.push_back(3); exp_ack_q.push_back(1'b1);
        wait_ack(11'h00A, "rr_ack_1_3");
        drop_and_check("rr_clear_1_3");
        req_i = 11'h003;
        exp_grant_q.push_back(0); exp_ack_q.push_back(1'b1);
        exp_grant_q.push_back(1); exp_ack_q.push_back(1'b1);
        wait_ack(11'h003, "rr_ack_0_1");
        drop_and_check("rr_clear_0_1");
    endtask

    task automatic test_clk_gate();
        do_reset();
        req_i[5] = 1'b1;
        exp_grant_q.push_back(5);
        exp_ack_q.push_back(1'b1);
        for (int k = 1; k <= SEQ_LEN; k++) begin
            logic [N-1:0] g;
            @(posedge HCLK); #1;
            g = N'($urandom);
            g[5] = 1'b0;
            clk_gate_en_i = g;
            @(negedge HCLK);
            checks++;
            if (clk_en_o[5] !== (k <= RC))
                $display("FAIL gate_cycle%0d: clk_en[5]=%b required %b", k, clk_en_o[5], (k <= RC));
            else passed++;
        end
        clk_gate_en_i = '1;
        drop_and_check("gate_clear");
    endtask

    task automatic test_withdraw();
        do_reset();
        req_i[7] = 1'b1;
        exp_grant_q.push_back(7);
        exp_ack_q.push_back(1'b0);
        for (int k = 1; k <= SEQ_LEN + 4; k++) begin
            @(posedge HCLK); #1;
            if (k == RC + 2) req_i[7] = 1'b0;
            @(negedge HCLK);
            checks++;
            if ({busy_o, ack_o[7]} !== {(k <= SEQ_LEN - 1), 1'b0})
                $display("FAIL withdraw_cycle%0d: {busy,ack}=%b%b required %b0",
                         k, busy_o, ack_o[7], (k <= SEQ_LEN - 1));
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_i[2] = 1'b1;
        exp_grant_q.push_back(2);
        exp_ack_q.push_back(1'b1);
        repeat (5) begin @(posedge HCLK); @(negedge HCLK); end
        checks++;
        if (busy_o !== 1'b1 || periph_rst_n_o[2] !== 1'b0)
            $display("FAIL async_pre: busy=%b rst_n=%b required 1/0", busy_o, periph_rst_n_o[2]);
        else passed++;
        @(posedge HCLK); #3 HRESETn = 1'b0;
        #1;
        checks++;
        if ({periph_rst_n_o[2], busy_o, ack_o} !== {1'b1, 1'b0, 11'h000})
            $display("FAIL async_mid: rst_n=%b busy=%b ack=%h required 1/0/000",
                     periph_rst_n_o[2], busy_o, ack_o);
        else passed++;
        exp_grant_q.delete();
        exp_ack_q.delete();
        exp_grant_q.push_back(2);
        exp_ack_q.push_back(1'b1);
        @(posedge HCLK); @(posedge HCLK); #1 HRESETn = 1'b1;
        wait_ack(11'h004, "async_restart_ack");
        drop_and_check("async_clear");
    endtask

`ifdef AHA_RST_SEQ_IRQ_EN
    task automatic test_irq();
        do_reset();
        req_i[2] = 1'b1;
        exp_grant_q.push_back(2);
        exp_ack_q.push_back(1'b1);
        wait_ack(11'h004, "irq_ack");
        checks++;
        if (last_idx_o !== 4'd2) $display("FAIL irq_last_idx: got %0d required 2", last_idx_o); else passed++;
        drop_and_check("irq_clear");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_ptr_reset();
        test_round_robin();
        test_clk_gate();
        test_withdraw();
        test_async_reset();
`ifdef AHA_RST_SEQ_IRQ_EN
        test_irq();
`endif
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checks++;
        if (exp_grant_q.size() != 0 || exp_ack_q.size() != 0)
            $display("FAIL scoreboard_drain: grants left %0d acks left %0d",
                     exp_grant_q.size(), exp_ack_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
